// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode command engine: power-up dummy clocks, 48-bit command issue and 1..5 byte response capture.
// Define SD_SPI_CRC7_EN to generate the command CRC7 in hardware instead of sending cmd_crc.
`timescale 1ns/1ps
module sd_spi_cmd_engine #(
    parameter int unsigned CLK_DIV_SLOW = 250,
    parameter int unsigned CLK_DIV_FAST = 4,
    parameter int unsigned NCR_MAX      = 8,
    parameter int unsigned INIT_CLOCKS  = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic [2:0]  resp_bytes,
    input  logic        fast_clk,
    output logic        resp_valid,
    output logic [39:0] resp_data,
    output logic        resp_timeout,
    output logic        busy,
    output logic        sd_cclk,
    output logic        sd_mosi_cmd,
    input  logic        sd_miso_data,
    output logic        sd_cs
);
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FRAME_W = 56;
    localparam int unsigned RESP_W  = 40;

    localparam logic [CNT_W-1:0] HALF_SLOW = CNT_W'(CLK_DIV_SLOW / 2);
    localparam logic [CNT_W-1:0] HALF_FAST = CNT_W'(CLK_DIV_FAST / 2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CLOCKS - 1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(NCR_MAX * 8);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_TAIL
    } state_t;

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_div_cnt, w_div_cnt_nx;
    logic [CNT_W-1:0]    r_half, w_half_nx;
    logic                r_sclk, w_sclk_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]    r_nbits, w_nbits_nx;
    logic [FRAME_W-1:0]  r_tx, w_tx_nx;
    logic                r_mosi, w_mosi_nx;
    logic                r_cs, w_cs_nx;
    logic [RESP_W-1:0]   r_shift, w_shift_nx;
    logic                r_to, w_to_nx;
    logic                r_resp_valid, w_resp_valid_nx;
    logic [RESP_W-1:0]   r_resp_data, w_resp_data_nx;
    logic                r_resp_timeout, w_resp_timeout_nx;
    logic                r_busy, w_busy_nx;
    logic                r_ready, w_ready_nx;

    logic                w_tick, w_rise, w_fall;
    logic [2:0]          w_nbytes;
    logic [6:0]          w_crc_field;
    logic [FRAME_W-1:0]  w_frame;
    logic [CNT_W-1:0]    w_half_sel;

    // Divider: sd_cclk toggles every r_half clk cycles while not idle
    assign w_tick = (r_state != S_IDLE) && (r_div_cnt == (r_half - ONE));
    assign w_rise = w_tick && !r_sclk;
    assign w_fall = w_tick && r_sclk;

    assign w_nbytes   = (resp_bytes == 3'd0) ? 3'd1 : ((resp_bytes > 3'd5) ? 3'd5 : resp_bytes);
    assign w_half_sel = fast_clk ? HALF_FAST : HALF_SLOW;

`ifdef SD_SPI_CRC7_EN
    localparam logic [CNT_W-1:0] CRC_FIRST = CNT_W'(8);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(47);
    localparam logic [CNT_W-1:0] CRC_OUT_E = CNT_W'(53);
    logic [6:0] r_crc, w_crc_nx, w_crc_upd;
    // Serial CRC7 (x^7+x^3+1) of the bit currently on MOSI
    assign w_crc_upd   = {r_crc[5:0], 1'b0} ^ (((r_mosi ^ r_crc[6]) != 1'b0) ? 7'h09 : 7'h00);
    assign w_crc_field = 7'h00;
`else
    assign w_crc_field = cmd_crc;
`endif

    assign w_frame = {8'hFF, 2'b01, cmd_index, cmd_arg, w_crc_field, 1'b1};

    always_comb begin
        w_state_nx        = r_state;
        w_div_cnt_nx      = r_div_cnt;
        w_half_nx         = r_half;
        w_sclk_nx         = r_sclk;
        w_cnt_nx          = r_cnt;
        w_nbits_nx        = r_nbits;
        w_tx_nx           = r_tx;
        w_mosi_nx         = r_mosi;
        w_cs_nx           = r_cs;
        w_shift_nx        = r_shift;
        w_to_nx           = r_to;
        w_resp_valid_nx   = 1'b0;
        w_resp_data_nx    = r_resp_data;
        w_resp_timeout_nx = r_resp_timeout;
        w_busy_nx         = r_busy;
        w_ready_nx        = r_ready;
`ifdef SD_SPI_CRC7_EN
        w_crc_nx          = r_crc;
`endif

        if (r_state != S_IDLE) begin
            w_div_cnt_nx = w_tick ? '0 : (r_div_cnt + ONE);
            if (w_tick) begin
                w_sclk_nx = ~r_sclk;
            end
        end

        unique case (r_state)
            S_IDLE: begin
                if (init_req) begin
                    w_state_nx   = S_INIT;
                    w_half_nx    = w_half_sel;
                    w_div_cnt_nx = '0;
                    w_cnt_nx     = '0;
                    w_busy_nx    = 1'b1;
                    w_ready_nx   = 1'b0;
                end else if (cmd_valid) begin
                    w_state_nx   = S_SEND;
                    w_half_nx    = w_half_sel;
                    w_div_cnt_nx = '0;
                    w_cnt_nx     = '0;
                    w_nbits_nx   = CNT_W'({w_nbytes, 3'b000});
                    w_tx_nx      = {w_frame[FRAME_W-2:0], 1'b1};
                    w_mosi_nx    = w_frame[FRAME_W-1];
                    w_cs_nx      = 1'b0;
                    w_shift_nx   = '0;
                    w_to_nx      = 1'b0;
                    w_busy_nx    = 1'b1;
                    w_ready_nx   = 1'b0;
`ifdef SD_SPI_CRC7_EN
                    w_crc_nx     = 7'h00;
`endif
                end
            end
            S_INIT: begin
                if (w_fall) begin
                    w_cnt_nx = r_cnt + ONE;
                    if (r_cnt == INIT_LAST) begin
                        w_state_nx = S_IDLE;
                        w_busy_nx  = 1'b0;
                        w_ready_nx = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // r_cnt is the index of the frame bit currently on MOSI
                if (w_fall) begin
                    w_cnt_nx = r_cnt + ONE;
                    w_tx_nx  = {r_tx[FRAME_W-2:0], 1'b1};
`ifdef SD_SPI_CRC7_EN
                    if (r_cnt >= CRC_FIRST && r_cnt <= CRC_LAST) begin
                        w_crc_nx = w_crc_upd;
                    end
                    if (r_cnt == CRC_LAST) begin
                        w_mosi_nx = w_crc_upd[6];
                        w_crc_nx  = {w_crc_upd[5:0], 1'b0};
                    end else if (r_cnt > CRC_LAST && r_cnt <= CRC_OUT_E) begin
                        w_mosi_nx = r_crc[6];
                        w_crc_nx  = {r_crc[5:0], 1'b0};
                    end else begin
                        w_mosi_nx = r_tx[FRAME_W-1];
                    end
`else
                    w_mosi_nx = r_tx[FRAME_W-1];
`endif
                    if (r_cnt == SEND_LAST) begin
                        w_state_nx = S_WAIT;
                        w_cnt_nx   = '0;
                        w_mosi_nx  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_rise) begin
                    if (!sd_miso_data) begin
                        w_state_nx = S_RECV;
                        w_shift_nx = {r_shift[RESP_W-2:0], 1'b0};
                        w_cnt_nx   = ONE;
                    end else begin
                        w_cnt_nx = r_cnt + ONE;
                    end
                end else if (w_fall && r_cnt == WAIT_MAX) begin
                    w_state_nx = S_TAIL;
                    w_cnt_nx   = '0;
                    w_to_nx    = 1'b1;
                end
            end
            S_RECV: begin
                if (w_rise) begin
                    w_shift_nx = {r_shift[RESP_W-2:0], sd_miso_data};
                    w_cnt_nx   = r_cnt + ONE;
                end else if (w_fall && r_cnt == r_nbits) begin
                    w_state_nx = S_TAIL;
                    w_cnt_nx   = '0;
                end
            end
            S_TAIL: begin
                if (w_fall) begin
                    w_cnt_nx = r_cnt + ONE;
                    if (r_cnt == TAIL_LAST) begin
                        w_state_nx        = S_IDLE;
                        w_cs_nx           = 1'b1;
                        w_resp_valid_nx   = 1'b1;
                        w_resp_data_nx    = r_shift;
                        w_resp_timeout_nx = r_to;
                        w_busy_nx         = 1'b0;
                        w_ready_nx        = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_div_cnt      <= '0;
            r_half         <= HALF_SLOW;
            r_sclk         <= 1'b0;
            r_cnt          <= '0;
            r_nbits        <= CNT_W'(8);
            r_tx           <= '1;
            r_mosi         <= 1'b1;
            r_cs           <= 1'b1;
            r_shift        <= '0;
            r_to           <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_data    <= '0;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
            r_ready        <= 1'b1;
`ifdef SD_SPI_CRC7_EN
            r_crc          <= 7'h00;
`endif
        end else begin
            r_state        <= w_state_nx;
            r_div_cnt      <= w_div_cnt_nx;
            r_half         <= w_half_nx;
            r_sclk         <= w_sclk_nx;
            r_cnt          <= w_cnt_nx;
            r_nbits        <= w_nbits_nx;
            r_tx           <= w_tx_nx;
            r_mosi         <= w_mosi_nx;
            r_cs           <= w_cs_nx;
            r_shift        <= w_shift_nx;
            r_to           <= w_to_nx;
            r_resp_valid   <= w_resp_valid_nx;
            r_resp_data    <= w_resp_data_nx;
            r_resp_timeout <= w_resp_timeout_nx;
            r_busy         <= w_busy_nx;
            r_ready        <= w_ready_nx;
`ifdef SD_SPI_CRC7_EN
            r_crc          <= w_crc_nx;
`endif
        end
    end

    assign cmd_ready    = r_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign resp_timeout = r_resp_timeout;
    assign busy         = r_busy;
    assign sd_cclk      = r_sclk;
    assign sd_mosi_cmd  = r_mosi;
    assign sd_cs        = r_cs;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine with a small SPI card model answering on MISO.
`timescale 1ns/1ps
module tb_sd_spi_cmd_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_req;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic [2:0]  resp_bytes;
    logic        fast_clk;
    logic        resp_valid;
    logic [39:0] resp_data;
    logic        resp_timeout;
    logic        busy;
    logic        sd_cclk;
    logic        sd_mosi_cmd;
    logic        miso;
    logic        sd_cs;

    int errors = 0;
    int checks = 0;

    // Card model state: bits to send MSB first after the 56-bit command
    logic [127:0] m_pat = '0;
    int           m_len = 0;
    int           m_idx = 0;
    logic [6:0]   m_bit;
    logic         prev_cs = 1'b1;
    logic         prev_sclk = 1'b0;
    int           mon_rise = 0;
    int           mon_init_rise = 0;
    int           mon_init_bad = 0;
    logic [55:0]  mon_cap = '0;
    time          mon_last_t = 0;
    time          mon_period = 0;

    sd_spi_cmd_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_req     (init_req),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .cmd_crc      (cmd_crc),
        .resp_bytes   (resp_bytes),
        .fast_clk     (fast_clk),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .sd_cclk      (sd_cclk),
        .sd_mosi_cmd  (sd_mosi_cmd),
        .sd_miso_data (miso),
        .sd_cs        (sd_cs)
    );

    always #5 clk = ~clk;

    // Card model: captures MOSI on rising sd_cclk, shifts the response out on falling sd_cclk
    always @(sd_cs or sd_cclk or rst_n) begin
        if (!rst_n) miso = 1'b1;
        if (prev_cs && !sd_cs) begin
            mon_rise = 0;
            mon_cap  = '0;
            m_idx    = 0;
            miso     = 1'b1;
        end
        if (!prev_sclk && sd_cclk) begin
            mon_period = $time - mon_last_t;
            mon_last_t = $time;
            if (!sd_cs) begin
                if (mon_rise < 56) mon_cap = {mon_cap[54:0], sd_mosi_cmd};
                mon_rise++;
            end else begin
                mon_init_rise++;
                if (sd_mosi_cmd !== 1'b1) mon_init_bad++;
            end
        end
        if (prev_sclk && !sd_cclk && !sd_cs && mon_rise >= 56) begin
            if (m_idx < m_len) begin
                m_bit = 7'(m_len - 1 - m_idx);
                miso  = m_pat[m_bit];
            end else begin
                miso = 1'b1;
            end
            m_idx++;
        end
        prev_cs   = sd_cs;
        prev_sclk = sd_cclk;
    end

    task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                             input logic [2:0] nb, input logic fast, input int limit,
                             output int cyc, output logic got, output logic ready_after,
                             output logic [39:0] data, output logic to);
        @(negedge clk);
        cmd_index  = idx;
        cmd_arg    = arg;
        cmd_crc    = crc;
        resp_bytes = nb;
        fast_clk   = fast;
        cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_index   = 6'h3F;
        cmd_arg     = 32'hDEADBEEF;
        cmd_crc     = 7'h00;
        fast_clk    = ~fast;
        ready_after = cmd_ready;
        cyc = 0;
        while (!resp_valid && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        got  = resp_valid;
        data = resp_data;
        to   = resp_timeout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_req = 1'b0; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0;
        cmd_crc = '0; resp_bytes = 3'd1; fast_clk = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sd_cclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b want=0", sd_cclk); end
        checks++; if (sd_mosi_cmd !== 1'b1) begin errors++; $display("FAIL reset_mosi got=%b want=1", sd_mosi_cmd); end
        checks++; if (sd_cs !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b want=1", sd_cs); end
        checks++; if (resp_valid !== 1'b0 || resp_timeout !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b%b want=00", resp_valid, resp_timeout); end
        checks++; if (resp_data !== 40'h0) begin errors++; $display("FAIL reset_data got=%h want=0", resp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_init_slow();
        int r0, b0, n, cs_low, rv;
        r0 = mon_init_rise; b0 = mon_init_bad; cs_low = 0; rv = 0;
        @(negedge clk);
        fast_clk = 1'b0; init_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        n = 0;
        while (busy && n < 25000) begin
            @(negedge clk);
            n++;
            if (!sd_cs) cs_low++;
            if (resp_valid) rv++;
        end
        checks++; if (n < 20000 || n > 20002) begin errors++; $display("FAIL init_len got=%0d want=20000", n); end
        checks++; if (mon_init_rise - r0 != 80) begin errors++; $display("FAIL init_clocks got=%0d want=80", mon_init_rise - r0); end
        checks++; if (mon_period != 64'd2500) begin errors++; $display("FAIL init_period got=%0t want=2500", mon_period); end
        checks++; if (mon_init_bad != b0 || cs_low != 0) begin errors++; $display("FAIL init_lines got bad=%0d cs_low=%0d want 0 0", mon_init_bad - b0, cs_low); end
        checks++; if (rv != 0) begin errors++; $display("FAIL init_no_resp got=%0d want=0", rv); end
        checks++; if (cmd_ready !== 1'b1 || sd_cclk !== 1'b0) begin errors++; $display("FAIL init_idle got ready=%b sclk=%b want 1 0", cmd_ready, sd_cclk); end
    endtask

    task automatic test_cmd0_slow();
        int cyc; logic got, rdy, to; logic [39:0] data;
        m_pat = {104'h0, 16'hFFFF, 8'h01}; m_len = 24;
        issue_cmd(6'd0, 32'h0, 7'h4A, 3'd1, 1'b0, 30000, cyc, got, rdy, data, to);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL cmd0_ready_drop got=%b want=0", rdy); end
        checks++; if (got !== 1'b1 || cyc < 22000 || cyc > 22002) begin errors++; $display("FAIL cmd0_latency got=%0d valid=%b want=22000", cyc, got); end
        checks++; if (mon_cap !== 56'hFF400000000095) begin errors++; $display("FAIL cmd0_frame got=%h want=ff400000000095", mon_cap); end
        checks++; if (data !== 40'h01 || to !== 1'b0) begin errors++; $display("FAIL cmd0_resp got=%h/%b want=01/0", data, to); end
        checks++; if (mon_period != 64'd2500) begin errors++; $display("FAIL cmd0_period got=%0t want=2500", mon_period); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_data !== 40'h01 || sd_cs !== 1'b1) begin errors++; $display("FAIL cmd0_after got v=%b d=%h cs=%b want 0 01 1", resp_valid, resp_data, sd_cs); end
    endtask

    task automatic test_cmd8_fast();
        int cyc; logic got, rdy, to; logic [39:0] data;
        m_pat = {80'h0, 8'hFF, 40'h01000001AA}; m_len = 48;
        issue_cmd(6'd8, 32'h000001AA, 7'h43, 3'd5, 1'b1, 2000, cyc, got, rdy, data, to);
        checks++; if (got !== 1'b1 || cyc < 448 || cyc > 450) begin errors++; $display("FAIL cmd8_latency got=%0d valid=%b want=448", cyc, got); end
        checks++; if (mon_cap !== 56'hFF48000001AA87) begin errors++; $display("FAIL cmd8_frame got=%h want=ff48000001aa87", mon_cap); end
        checks++; if (data !== 40'h01000001AA || to !== 1'b0) begin errors++; $display("FAIL cmd8_resp got=%h/%b want=01000001aa/0", data, to); end
        checks++; if (mon_period != 64'd40) begin errors++; $display("FAIL cmd8_period got=%0t want=40", mon_period); end
    endtask

    task automatic test_timeout();
        int cyc; logic got, rdy, to; logic [39:0] data;
        m_len = 0;
        issue_cmd(6'd55, 32'h0, 7'h32, 3'd1, 1'b1, 2000, cyc, got, rdy, data, to);
        checks++; if (got !== 1'b1 || cyc < 512 || cyc > 514) begin errors++; $display("FAIL timeout_latency got=%0d valid=%b want=512", cyc, got); end
        checks++; if (to !== 1'b1 || data !== 40'h0) begin errors++; $display("FAIL timeout_flag got=%b/%h want=1/0", to, data); end
    endtask

    task automatic test_reset_mid_send();
        int n, rv, cyc; logic got, rdy, to; logic [39:0] data;
        m_len = 0;
        @(negedge clk);
        cmd_index = 6'd17; cmd_arg = 32'h12345678; cmd_crc = 7'h11; resp_bytes = 3'd1;
        fast_clk = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (mon_rise < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++; if (mon_rise != 20 || sd_cclk !== 1'b1) begin errors++; $display("FAIL midsend_reach got rise=%0d sclk=%b want 20 1", mon_rise, sd_cclk); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (sd_cs !== 1'b1 || sd_cclk !== 1'b0) begin errors++; $display("FAIL midsend_async got cs=%b sclk=%b want 1 0", sd_cs, sd_cclk); end
        checks++; if (busy !== 1'b0 || sd_mosi_cmd !== 1'b1) begin errors++; $display("FAIL midsend_state got busy=%b mosi=%b want 0 1", busy, sd_mosi_cmd); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid || !sd_cs) rv++;
        end
        checks++; if (rv != 0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL midsend_quiet got=%0d ready=%b want 0 1", rv, cmd_ready); end
        m_pat = {104'h0, 16'hFFFF, 8'h01}; m_len = 24;
        issue_cmd(6'd0, 32'h0, 7'h4A, 3'd0, 1'b1, 2000, cyc, got, rdy, data, to);
        checks++; if (got !== 1'b1 || cyc < 352 || cyc > 354) begin errors++; $display("FAIL midsend_cmd0_latency got=%0d valid=%b want=352", cyc, got); end
        checks++; if (mon_cap !== 56'hFF400000000095 || data !== 40'h01 || to !== 1'b0) begin errors++; $display("FAIL midsend_cmd0 got frame=%h resp=%h to=%b", mon_cap, data, to); end
    endtask

    task automatic test_init_priority();
        int r0, n, cyc;
        m_pat = {80'h0, 8'hFF, 40'h0102030405}; m_len = 48;
        r0 = mon_init_rise;
        @(negedge clk);
        cmd_index = 6'd0; cmd_arg = 32'h0; cmd_crc = 7'h4A; resp_bytes = 3'd6; fast_clk = 1'b1;
        init_req = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        checks++; if (busy !== 1'b1 || sd_cs !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL prio_init got busy=%b cs=%b ready=%b want 1 1 0", busy, sd_cs, cmd_ready); end
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (mon_init_rise - r0 != 80 || n < 320 || n > 322) begin errors++; $display("FAIL prio_init_len got clocks=%0d cycles=%0d want 80 320", mon_init_rise - r0, n); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (sd_cs !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL prio_accept got cs=%b ready=%b want 0 0", sd_cs, cmd_ready); end
        cyc = 0;
        while (!resp_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (resp_valid !== 1'b1 || cyc < 448 || cyc > 450) begin errors++; $display("FAIL prio_latency got=%0d valid=%b want=448", cyc, resp_valid); end
        checks++; if (resp_data !== 40'h0102030405 || resp_timeout !== 1'b0) begin errors++; $display("FAIL prio_resp got=%h/%b want=0102030405/0", resp_data, resp_timeout); end
    endtask

    initial begin
        test_reset();
        test_init_slow();
        test_cmd0_slow();
        test_cmd8_fast();
        test_timeout();
        test_reset_mid_send();
        test_init_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
